// File: rtl/mccu_pkg.sv
// mccu_pkg: state encodings, ALU/mux codes, decoded-instruction struct and ALU-control helper
package mccu_pkg;
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;
  localparam logic [1:0] SA_PC = 2'b00;
  localparam logic [1:0] SA_A  = 2'b01;
  localparam logic [1:0] SA_SA = 2'b10;
  localparam logic [1:0] SB_B   = 2'b00;
  localparam logic [1:0] SB_4   = 2'b01;
  localparam logic [1:0] SB_IMM = 2'b10;
  localparam logic [1:0] SB_BR  = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_A   = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;
  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  } dec_t;
  function automatic logic [3:0] alu_code(dec_t d);
    return (d.i_add | d.i_addi | d.i_lw | d.i_sw) ? ALU_ADD :
           (d.i_sub | d.i_beq | d.i_bne)          ? ALU_SUB :
           (d.i_and | d.i_andi)                   ? ALU_AND :
           (d.i_or | d.i_ori)                     ? ALU_OR  :
           (d.i_xor | d.i_xori)                   ? ALU_XOR :
           d.i_lui                                ? ALU_LUI :
           d.i_sll                                ? ALU_SLL :
           d.i_srl                                ? ALU_SRL :
           d.i_sra                                ? ALU_SRA : ALU_ADD;
  endfunction
endpackage

// File: rtl/mccu_if.sv
// mccu_if: control-unit/datapath bundle; master = control unit (IR fields, flags in; strobes, muxes, status out), slave = datapath
interface mccu_if #(parameter int CNT_W = 32);
  logic [5:0] op, func;
  logic z, mem_rdy;
  logic mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [3:0] aluc;
  logic [2:0] state;
  logic halted;
  logic [CNT_W-1:0] instret;
  modport master (
    input  op, func, z, mem_rdy,
    output mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
    output alusrca, alusrcb, pcsrc, aluc, state, halted, instret
  );
  modport slave (
    output op, func, z, mem_rdy,
    input  mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
    input  alusrca, alusrcb, pcsrc, aluc, state, halted, instret
  );
endinterface

// File: rtl/mccu_decode.sv
// mccu_decode: one-hot decode of op/func into the 20 supported instructions (d) plus illegal flag
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       d,
  output logic       illegal
);
  logic r;
  assign r = op == 6'h00;
  always_comb begin
    d = '0;
    d.i_add  = r && func == 6'h20;
    d.i_sub  = r && func == 6'h22;
    d.i_and  = r && func == 6'h24;
    d.i_or   = r && func == 6'h25;
    d.i_xor  = r && func == 6'h26;
    d.i_sll  = r && func == 6'h00;
    d.i_srl  = r && func == 6'h02;
    d.i_sra  = r && func == 6'h03;
    d.i_jr   = r && func == 6'h08;
    d.i_addi = op == 6'h08;
    d.i_andi = op == 6'h0C;
    d.i_ori  = op == 6'h0D;
    d.i_xori = op == 6'h0E;
    d.i_lw   = op == 6'h23;
    d.i_sw   = op == 6'h2B;
    d.i_beq  = op == 6'h04;
    d.i_bne  = op == 6'h05;
    d.i_lui  = op == 6'h0F;
    d.i_j    = op == 6'h02;
    d.i_jal  = op == 6'h03;
    illegal  = ~|d;
  end
endmodule

// File: rtl/mccu_fsm.sv
// mccu_fsm: multi-cycle MIPS control FSM; clk, rst (sync, high) and bus (mccu_if.master: op/func/z/mem_rdy in, datapath controls, state, halted, instret out)
module mccu_fsm
  import mccu_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter bit TRAP_ILLEGAL  = 1'b1,
  parameter int CNT_W         = 32
) (
  input logic    clk,
  input logic    rst,
  mccu_if.master bus
);
  state_t st, nxt;
  dec_t d;
  logic illegal, rdy, shf, ialu, jmp;
  logic [CNT_W-1:0] cnt;
  mccu_decode u_dec (.op(bus.op), .func(bus.func), .d(d), .illegal(illegal));
  assign rdy  = MEM_HANDSHAKE ? bus.mem_rdy : 1'b1;
  assign shf  = d.i_sll | d.i_srl | d.i_sra;
  assign ialu = d.i_addi | d.i_andi | d.i_ori | d.i_xori | d.i_lui;
  assign jmp  = d.i_j | d.i_jal | d.i_jr;
  assign bus.state   = st;
  assign bus.halted  = st == S_HALT;
  assign bus.instret = cnt;
  always_comb begin
    bus.mem_req = 1'b0;
    bus.wpc     = 1'b0;
    bus.wir     = 1'b0;
    bus.wmem    = 1'b0;
    bus.wreg    = 1'b0;
    bus.iord    = 1'b0;
    bus.regrt   = 1'b0;
    bus.m2reg   = 1'b0;
    bus.jal     = 1'b0;
    bus.sext    = 1'b0;
    bus.shift   = 1'b0;
    bus.alusrca = SA_PC;
    bus.alusrcb = SB_B;
    bus.aluc    = ALU_ADD;
    bus.pcsrc   = PC_ALU;
    nxt         = st;
    case (st)
      S_IF: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = SB_4;
        bus.wpc     = rdy;
        bus.wir     = rdy;
        nxt         = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        // branch target is computed here speculatively and parked in ALUout
        bus.alusrcb = SB_BR;
        bus.sext    = 1'b1;
        bus.wpc     = jmp;
        bus.pcsrc   = d.i_jr ? PC_A : jmp ? PC_JMP : PC_ALU;
        bus.wreg    = d.i_jal;
        bus.jal     = d.i_jal;
        nxt         = jmp ? S_IF : !illegal ? S_EXE : TRAP_ILLEGAL ? S_HALT : S_IF;
      end
      S_EXE: begin
        bus.aluc    = alu_code(d);
        bus.shift   = shf;
        bus.alusrca = shf ? SA_SA : SA_A;
        bus.alusrcb = (ialu | d.i_lw | d.i_sw) ? SB_IMM : SB_B;
        bus.sext    = d.i_addi | d.i_lw | d.i_sw | d.i_beq | d.i_bne;
        bus.pcsrc   = (d.i_beq | d.i_bne) ? PC_OUT : PC_ALU;
        bus.wpc     = (d.i_beq & bus.z) | (d.i_bne & ~bus.z);
        nxt         = (d.i_beq | d.i_bne) ? S_IF : (d.i_lw | d.i_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.wmem    = d.i_sw;
        nxt         = !rdy ? S_MEM : d.i_lw ? S_WB : S_IF;
      end
      S_WB: begin
        bus.wreg  = 1'b1;
        bus.regrt = ialu | d.i_lw;
        bus.m2reg = d.i_lw;
        nxt       = S_IF;
      end
      default: nxt = S_HALT;
    endcase
    // reset kills every side effect immediately, even mid-instruction
    if (rst) begin
      bus.mem_req = 1'b0;
      bus.wpc     = 1'b0;
      bus.wir     = 1'b0;
      bus.wmem    = 1'b0;
      bus.wreg    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_IF;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (nxt == S_IF && st != S_IF) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mccu_fsm.sv
// tb_mccu_fsm: table-driven + scoreboard bench for mccu_fsm (handshake on, illegal trap on)
module tb_mccu_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mccu_if #(.CNT_W(32)) bus ();
  mccu_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b1), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [2:0] st;
    logic wpc, wir, wmem, wreg, mem_req, iord, regrt, m2reg, jal, sext, shift;
    logic [1:0] sa, sb, pc;
    logic [3:0] aluc;
  } exp_t;
  typedef struct packed {
    logic [5:0] op, func;
    logic z;
    logic [2:0] len;
    logic [4:0][2:0] sts;
    logic [3:0] aluc;
    logic [1:0] sa, sb;
    logic sext, shift, br, bwpc, regrt, m2reg;
    logic [1:0] idj;
  } ent_t;
  localparam logic [14:0] S_R  = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] S_LW = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] S_SW = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] S_BR = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] S_J  = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret = '0;
  exp_t q[$];
  ent_t tbl[17];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  function automatic ent_t mk(logic [5:0] op, logic [5:0] func, logic z, logic [2:0] len, logic [14:0] sts,
                              logic [3:0] aluc, logic [1:0] sa, logic [1:0] sb, logic [5:0] fl, logic [1:0] idj);
    ent_t e;
    e.op = op;
    e.func = func;
    e.z = z;
    e.len = len;
    e.sts = sts;
    e.aluc = aluc;
    e.sa = sa;
    e.sb = sb;
    {e.sext, e.shift, e.br, e.bwpc, e.regrt, e.m2reg} = fl;
    e.idj = idj;
    return e;
  endfunction
  function automatic exp_t exp_for(ent_t e, logic [2:0] s);
    exp_t x = '0;
    x.st = s;
    case (s)
      3'd0: begin x.mem_req = 1'b1; x.wpc = 1'b1; x.wir = 1'b1; x.sb = 2'b01; end
      3'd1: begin
        x.sb = 2'b11;
        x.sext = 1'b1;
        if (e.idj != 2'd0) begin
          x.wpc = 1'b1;
          x.pc = (e.idj == 2'd3) ? 2'b10 : 2'b11;
          x.wreg = e.idj == 2'd2;
          x.jal = e.idj == 2'd2;
        end
      end
      3'd2: begin
        x.aluc = e.aluc;
        x.sa = e.sa;
        x.sb = e.sb;
        x.sext = e.sext;
        x.shift = e.shift;
        if (e.br) begin x.pc = 2'b01; x.wpc = e.bwpc; end
      end
      3'd3: begin x.mem_req = 1'b1; x.iord = 1'b1; x.wmem = e.op == 6'h2B; end
      3'd4: begin x.wreg = 1'b1; x.regrt = e.regrt; x.m2reg = e.m2reg; end
      default: ;
    endcase
    return x;
  endfunction
  function automatic exp_t get_act();
    exp_t a;
    a.st = bus.state;
    a.wpc = bus.wpc;
    a.wir = bus.wir;
    a.wmem = bus.wmem;
    a.wreg = bus.wreg;
    a.mem_req = bus.mem_req;
    a.iord = bus.iord;
    a.regrt = bus.regrt;
    a.m2reg = bus.m2reg;
    a.jal = bus.jal;
    a.sext = bus.sext;
    a.shift = bus.shift;
    a.sa = bus.alusrca;
    a.sb = bus.alusrcb;
    a.pc = bus.pcsrc;
    a.aluc = bus.aluc;
    return a;
  endfunction
  task automatic step(input string nm, input logic rdy, input logic [6:0] exp);
    bus.mem_rdy = rdy;
    @(negedge clk);
    chk(nm, {bus.state, bus.wpc, bus.wir, bus.wmem, bus.mem_req}, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = '0;
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_instret", bus.instret, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    bus.op = 6'h00;
    bus.func = 6'h00;
    bus.z = 1'b0;
    bus.mem_rdy = 1'b1;
    tbl[0]  = mk(6'h00, 6'h20, 1'b0, 3'd4, S_R,  4'b0000, 2'b01, 2'b00, 6'b000000, 2'd0);
    tbl[1]  = mk(6'h00, 6'h22, 1'b0, 3'd4, S_R,  4'b0100, 2'b01, 2'b00, 6'b000000, 2'd0);
    tbl[2]  = mk(6'h00, 6'h26, 1'b0, 3'd4, S_R,  4'b0010, 2'b01, 2'b00, 6'b000000, 2'd0);
    tbl[3]  = mk(6'h00, 6'h00, 1'b0, 3'd4, S_R,  4'b0011, 2'b10, 2'b00, 6'b010000, 2'd0);
    tbl[4]  = mk(6'h00, 6'h03, 1'b0, 3'd4, S_R,  4'b1111, 2'b10, 2'b00, 6'b010000, 2'd0);
    tbl[5]  = mk(6'h08, 6'h20, 1'b0, 3'd4, S_R,  4'b0000, 2'b01, 2'b10, 6'b100010, 2'd0);
    tbl[6]  = mk(6'h0D, 6'h00, 1'b0, 3'd4, S_R,  4'b0101, 2'b01, 2'b10, 6'b000010, 2'd0);
    tbl[7]  = mk(6'h0F, 6'h00, 1'b0, 3'd4, S_R,  4'b0110, 2'b01, 2'b10, 6'b000010, 2'd0);
    tbl[8]  = mk(6'h23, 6'h00, 1'b0, 3'd5, S_LW, 4'b0000, 2'b01, 2'b10, 6'b100011, 2'd0);
    tbl[9]  = mk(6'h2B, 6'h00, 1'b0, 3'd4, S_SW, 4'b0000, 2'b01, 2'b10, 6'b100000, 2'd0);
    tbl[10] = mk(6'h04, 6'h00, 1'b1, 3'd3, S_BR, 4'b0100, 2'b01, 2'b00, 6'b101100, 2'd0);
    tbl[11] = mk(6'h04, 6'h00, 1'b0, 3'd3, S_BR, 4'b0100, 2'b01, 2'b00, 6'b101000, 2'd0);
    tbl[12] = mk(6'h05, 6'h00, 1'b0, 3'd3, S_BR, 4'b0100, 2'b01, 2'b00, 6'b101100, 2'd0);
    tbl[13] = mk(6'h05, 6'h00, 1'b1, 3'd3, S_BR, 4'b0100, 2'b01, 2'b00, 6'b101000, 2'd0);
    tbl[14] = mk(6'h02, 6'h00, 1'b0, 3'd2, S_J,  4'b0000, 2'b00, 2'b00, 6'b000000, 2'd1);
    tbl[15] = mk(6'h03, 6'h00, 1'b0, 3'd2, S_J,  4'b0000, 2'b00, 2'b00, 6'b000000, 2'd2);
    tbl[16] = mk(6'h00, 6'h08, 1'b0, 3'd2, S_J,  4'b0000, 2'b00, 2'b00, 6'b000000, 2'd3);
    repeat (3) begin
      @(negedge clk);
      chk("rst_strobes", {bus.wpc, bus.wir, bus.wmem, bus.wreg, bus.mem_req}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rel_state", bus.state, 0);
    chk("rel_if", {bus.wpc, bus.wir, bus.mem_req, bus.alusrcb}, 5'b11101);
    chk("rel_instret", bus.instret, 0);
    chk("rel_halted", bus.halted, 0);
    for (int i = 0; i < 17; i++) begin
      bus.op = tbl[i].op;
      bus.func = tbl[i].func;
      bus.z = tbl[i].z;
      for (int k = 0; k < int'(tbl[i].len); k++) q.push_back(exp_for(tbl[i], tbl[i].sts[k]));
      for (int k = 0; k < int'(tbl[i].len); k++) begin
        @(negedge clk);
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty act=0 exp=1");
        end else chk($sformatf("vec%0d_c%0d", i, k), get_act(), q.pop_front());
        @(posedge clk);
        #1;
      end
      exp_ret++;
      chk($sformatf("vec%0d_instret", i), bus.instret, exp_ret);
      chk($sformatf("vec%0d_ret_if", i), bus.state, 0);
    end
    bus.op = 6'h2B;
    bus.func = 6'h00;
    step("if_wait", 1'b0, {3'd0, 4'b0001});
    step("if_wait", 1'b0, {3'd0, 4'b0001});
    step("if_go", 1'b1, {3'd0, 4'b1101});
    step("sw_id", 1'b1, {3'd1, 4'b0000});
    step("sw_exe", 1'b1, {3'd2, 4'b0000});
    step("sw_mem_wait", 1'b0, {3'd3, 4'b0011});
    step("sw_mem_wait", 1'b0, {3'd3, 4'b0011});
    step("sw_mem_go", 1'b1, {3'd3, 4'b0011});
    exp_ret++;
    chk("sw_instret", bus.instret, exp_ret);
    chk("sw_ret_if", bus.state, 0);
    bus.op = 6'h23;
    step("lw_if", 1'b1, {3'd0, 4'b1101});
    step("lw_id", 1'b1, {3'd1, 4'b0000});
    step("lw_exe", 1'b1, {3'd2, 4'b0000});
    rst = 1'b1;
    #1;
    chk("abort_strobes", {bus.wpc, bus.wir, bus.wmem, bus.wreg, bus.mem_req}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = '0;
    #1;
    chk("abort_state", bus.state, 0);
    chk("abort_instret", bus.instret, exp_ret);
    bus.op = 6'h3F;
    step("ill_if", 1'b1, {3'd0, 4'b1101});
    step("ill_id", 1'b1, {3'd1, 4'b0000});
    exp_ret++;
    for (int k = 0; k < 3; k++) begin
      step("halt", 1'b1, {3'd5, 4'b0000});
      chk("halt_flag", bus.halted, 1);
      chk("halt_instret", bus.instret, exp_ret - 1);
    end
    do_reset();
    bus.op = 6'h00;
    bus.func = 6'h3F;
    step("illr_if", 1'b1, {3'd0, 4'b1101});
    step("illr_id", 1'b1, {3'd1, 4'b0000});
    step("illr_halt", 1'b1, {3'd5, 4'b0000});
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
